reg_uart_bridge: RTL and testbench

Byte-stream command bridge that turns host frames from the UART receiver into single register accesses on the register bus, then returns an acknowledge or read data through the UART transmitter. It sits directly upstream of the system register block as the register-bus master. It issues write pulses and read requests, waits for read-valid, and reports bus timeouts.

---
 rtl/reg_uart_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_reg_uart_bridge.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_uart_bridge.sv
// reg_uart_bridge
//   Turns host byte frames from the UART receiver into single register-bus
//   accesses and returns an acknowledge, read data or error code through the
//   UART transmitter.
//
//   Frames:    'W' ADDR D3 D2 D1 D0  -> write, reply 'K'
//              'R' ADDR              -> read,  reply 'K' + 4 data bytes (MSB first)
//                                               or 'T' on read timeout
//              any other first byte  -> reply 'E'
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   RX_DATA, RX_VLD   received byte and its one-cycle strobe (no backpressure)
//   TX_DATA, TX_VLD   byte to transmit, held until TX_RDY accepts it
//   TX_RDY            transmitter ready
//   WREN, WADR, WDAT  one-cycle write strobe, byte address, write data
//   RDEN, RADR        one-cycle read strobe, byte address
//   RDAT, RVLD        read data and its valid strobe
//   BUSY              high whenever the bridge is not idle
module reg_uart_bridge #(
  parameter int P_RD_TIMEOUT   = 16,
  parameter int P_BYTE_TIMEOUT = 5_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VLD,
  output logic [7:0]  TX_DATA,
  output logic        TX_VLD,
  input  logic        TX_RDY,
  output logic        WREN,
  output logic [7:0]  WADR,
  output logic [31:0] WDAT,
  output logic        RDEN,
  output logic [7:0]  RADR,
  input  logic [31:0] RDAT,
  input  logic        RVLD,
  output logic        BUSY
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_T = 8'h54;
  localparam logic [7:0] RSP_E = 8'h45;

  localparam int BT_W = $clog2(P_BYTE_TIMEOUT + 1);
  localparam int RT_W = $clog2(P_RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic            cmd_rd;     // latched command: 1 = read, 0 = write
  logic [7:0]      addr_q;     // write address, published on WADR only with the data
  logic [1:0]      byte_cnt;   // data bytes received so far in a write frame
  logic [23:0]     shift_q;    // first three data bytes, MSB first
  logic [BT_W-1:0] byte_tmr;   // idle cycles since the last byte inside a frame
  logic [RT_W-1:0] rd_tmr;     // cycles spent in RD_WAIT
  logic [39:0]     resp_buf;   // response bytes, next byte to send in [39:32]
  logic [2:0]      resp_left;  // response bytes still to be accepted

  logic is_cmd;
  logic byte_expired;
  logic rd_expired;
  logic tx_fire;

  assign is_cmd       = (RX_DATA == CMD_W) || (RX_DATA == CMD_R);
  assign byte_expired = (byte_tmr == BT_W'(P_BYTE_TIMEOUT));
  assign rd_expired   = (rd_tmr == RT_W'(P_RD_TIMEOUT));
  // Decoded from the state register rather than from TX_VLD to keep the
  // combinational process free of feedback through its own outputs.
  assign tx_fire      = (state == S_RESP) && TX_RDY;

  // Next state and strobes; every output is a decode of registered state,
  // so WREN/RDEN/TX_VLD/TX_DATA change only on the clock edge.
  always_comb begin
    state_nxt = state;
    TX_VLD    = 1'b0;
    WREN      = 1'b0;
    RDEN      = 1'b0;
    BUSY      = 1'b1;
    TX_DATA   = resp_buf[39:32];
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (RX_VLD) state_nxt = is_cmd ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        if (RX_VLD)            state_nxt = cmd_rd ? S_RD_REQ : S_DATA;
        else if (byte_expired) state_nxt = S_IDLE;
      end
      S_DATA: begin
        if (RX_VLD) begin
          if (byte_cnt == 2'd3) state_nxt = S_WR;
        end else if (byte_expired) begin
          state_nxt = S_IDLE;
        end
      end
      S_WR: begin
        WREN      = 1'b1;
        state_nxt = S_RESP;
      end
      S_RD_REQ: begin
        RDEN      = 1'b1;
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // RVLD arriving on the expiry cycle still produces a data response.
        if (RVLD || rd_expired) state_nxt = S_RESP;
      end
      S_RESP: begin
        TX_VLD = 1'b1;
        if (tx_fire && (resp_left == 3'd1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cmd_rd    <= 1'b0;
      addr_q    <= 8'h00;
      byte_cnt  <= 2'd0;
      shift_q   <= 24'h0;
      byte_tmr  <= '0;
      rd_tmr    <= '0;
      resp_buf  <= 40'h0;
      resp_left <= 3'd0;
      WADR      <= 8'h00;
      WDAT      <= 32'h0;
      RADR      <= 8'h00;
    end else begin
      state <= state_nxt;

      // Inter-byte timer only runs while a frame is being collected.
      if (RX_VLD || !((state == S_ADDR) || (state == S_DATA)))
        byte_tmr <= '0;
      else
        byte_tmr <= byte_tmr + 1'b1;

      // Zero on the first RD_WAIT cycle, so expiry lands on cycle P_RD_TIMEOUT.
      if (state == S_RD_WAIT) rd_tmr <= rd_tmr + 1'b1;
      else                    rd_tmr <= '0;

      case (state)
        S_IDLE: begin
          if (RX_VLD) begin
            cmd_rd <= (RX_DATA == CMD_R);
            if (!is_cmd) begin
              resp_buf  <= {RSP_E, 32'h0};
              resp_left <= 3'd1;
            end
          end
        end
        S_ADDR: begin
          if (RX_VLD) begin
            addr_q   <= RX_DATA;
            byte_cnt <= 2'd0;
            if (cmd_rd) RADR <= RX_DATA;
          end
        end
        S_DATA: begin
          if (RX_VLD) begin
            shift_q  <= {shift_q[15:0], RX_DATA};
            byte_cnt <= byte_cnt + 2'd1;
            // WADR/WDAT are only updated together with a complete frame so they
            // hold the last written values while the next frame is collected.
            if (byte_cnt == 2'd3) begin
              WADR <= addr_q;
              WDAT <= {shift_q, RX_DATA};
            end
          end
        end
        S_WR: begin
          resp_buf  <= {RSP_K, 32'h0};
          resp_left <= 3'd1;
        end
        S_RD_WAIT: begin
          if (RVLD) begin
            resp_buf  <= {RSP_K, RDAT};
            resp_left <= 3'd5;
          end else if (rd_expired) begin
            resp_buf  <= {RSP_T, 32'h0};
            resp_left <= 3'd1;
          end
        end
        S_RESP: begin
          if (tx_fire) begin
            resp_buf  <= {resp_buf[31:0], 8'h00};
            resp_left <= resp_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_uart_bridge.sv
// Testbench for reg_uart_bridge: directed host frames, an emulated register
// block answering reads three cycles after RDEN, and a frame-level model that
// predicts bus accesses and response bytes.
module tb_reg_uart_bridge;

  localparam int RD_TO   = 16;
  localparam int BYTE_TO = 100;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_VLD;
  logic [7:0]  TX_DATA;
  logic        TX_VLD;
  logic        TX_RDY;
  logic        WREN;
  logic [7:0]  WADR;
  logic [31:0] WDAT;
  logic        RDEN;
  logic [7:0]  RADR;
  logic [31:0] RDAT;
  logic        RVLD;
  logic        BUSY;

  reg_uart_bridge #(
    .P_RD_TIMEOUT  (RD_TO),
    .P_BYTE_TIMEOUT(BYTE_TO)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .RX_DATA(RX_DATA),
    .RX_VLD (RX_VLD),
    .TX_DATA(TX_DATA),
    .TX_VLD (TX_VLD),
    .TX_RDY (TX_RDY),
    .WREN   (WREN),
    .WADR   (WADR),
    .WDAT   (WDAT),
    .RDEN   (RDEN),
    .RADR   (RADR),
    .RDAT   (RDAT),
    .RVLD   (RVLD),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Frame-level expectations
  logic [7:0]  exp_tx[$];
  logic [39:0] exp_wr[$];   // {addr, data}
  logic [7:0]  exp_rd[$];
  logic [31:0] mdl_regs [256];

  // Emulated register block contents (fed by DUT writes)
  logic [31:0] bus_regs [256];

  int tx_mode    = 0;   // 0: always ready, 1: random, 2: never ready
  bit rd_answer  = 1'b1;
  int stray_req  = 0;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got unexpected/missing event, expected none at %0t", nm, $time);
  endtask

  // Register block: writes land in bus_regs, reads answered after 3 cycles.
  always @(posedge CLK) begin
    if (!RST && WREN) bus_regs[WADR] <= WDAT;
  end

  initial begin
    int cd;
    int stray_seen;
    logic [7:0] ra;
    cd = 0;
    stray_seen = 0;
    ra = 8'h00;
    RVLD = 1'b0;
    RDAT = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      RVLD = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          RVLD = 1'b1;
          RDAT = bus_regs[ra];
        end
      end
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        RVLD = 1'b1;
        RDAT = 32'hBAD0_BAD0;
      end
      if (RDEN && rd_answer) begin
        cd = 3;
        ra = RADR;
      end
    end
  end

  // Transmitter ready
  initial begin
    TX_RDY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (tx_mode)
        0:       TX_RDY = 1'b1;
        1:       TX_RDY = 1'($urandom_range(0, 1));
        default: TX_RDY = 1'b0;
      endcase
    end
  end

  // Per-cycle compare against the frame model
  initial begin
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    logic [39:0] e;
    pv = 1'b0;
    pr = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge CLK);
      if (RST) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("tx_vld_hold", {39'h0, TX_VLD}, 40'h1);
          chk("tx_data_hold", {32'h0, TX_DATA}, {32'h0, pd});
        end
        if (WREN) begin
          if (exp_wr.size() == 0) fail_evt("wren_unexpected");
          else begin
            e = exp_wr.pop_front();
            chk("wadr", {32'h0, WADR}, {32'h0, e[39:32]});
            chk("wdat", {8'h0, WDAT}, {8'h0, e[31:0]});
          end
        end
        if (RDEN) begin
          if (exp_rd.size() == 0) fail_evt("rden_unexpected");
          else begin
            e = {32'h0, exp_rd.pop_front()};
            chk("radr", {32'h0, RADR}, e);
          end
        end
        if (TX_VLD && TX_RDY) begin
          if (exp_tx.size() == 0) fail_evt("tx_unexpected");
          else begin
            e = {32'h0, exp_tx.pop_front()};
            chk("tx_byte", {32'h0, TX_DATA}, e);
          end
        end
        pv = TX_VLD;
        pr = TX_RDY;
        pd = TX_DATA;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    RX_DATA = b;
    RX_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_VLD  = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    exp_wr.push_back({a, d});
    exp_tx.push_back(8'h4B);
    mdl_regs[a] = d;
    send_byte(8'h57);
    send_byte(a);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic do_read(input logic [7:0] a, input bit ans);
    rd_answer = ans;
    exp_rd.push_back(a);
    if (ans) begin
      exp_tx.push_back(8'h4B);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(mdl_regs[a][8*i +: 8]);
    end else begin
      exp_tx.push_back(8'h54);
    end
    send_byte(8'h52);
    send_byte(a);
  endtask

  task automatic wait_tx(output int k);
    k = 0;
    while (!TX_VLD && k < 100) begin
      @(posedge CLK);
      #1;
      k++;
    end
  endtask

  task automatic wait_idle(input int limit);
    int c;
    c = 0;
    while ((BUSY || TX_VLD) && c < limit) begin
      @(posedge CLK);
      #1;
      c++;
    end
    if (c >= limit) fail_evt("idle_wait_expired");
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_txvld"}, {39'h0, TX_VLD}, 40'h0);
    chk({tag, "_wren"},  {39'h0, WREN},   40'h0);
    chk({tag, "_rden"},  {39'h0, RDEN},   40'h0);
    chk({tag, "_busy"},  {39'h0, BUSY},   40'h0);
    chk({tag, "_txdata"}, {32'h0, TX_DATA}, 40'h0);
    chk({tag, "_wadr"},  {32'h0, WADR},   40'h0);
    chk({tag, "_radr"},  {32'h0, RADR},   40'h0);
    chk({tag, "_wdat"},  {8'h0, WDAT},    40'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) begin
      bus_regs[i] = 32'h0;
      mdl_regs[i] = 32'h0;
    end
    bus_regs[8'h00] = 32'h2021_1006;
    mdl_regs[8'h00] = 32'h2021_1006;
    bus_regs[8'h04] = 32'hDEAD_BEEF;
    mdl_regs[8'h04] = 32'hDEAD_BEEF;

    RX_VLD  = 1'b0;
    RX_DATA = 8'h00;
    RST     = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset("rst_init");
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Write 0x12345678 to 0x08
    do_write(8'h08, 32'h1234_5678);
    chk("wr_wren_n1", {39'h0, WREN}, 40'h1);
    chk("wr_wadr_n1", {32'h0, WADR}, 40'h08);
    chk("wr_wdat_n1", {8'h0, WDAT}, 40'h1234_5678);
    @(posedge CLK);
    #1;
    chk("wr_wren_n2", {39'h0, WREN}, 40'h0);
    chk("wr_txvld_n2", {39'h0, TX_VLD}, 40'h1);
    chk("wr_txdata_n2", {32'h0, TX_DATA}, 40'h4B);
    @(posedge CLK);
    #1;
    chk("wr_busy_n3", {39'h0, BUSY}, 40'h0);
    chk("wr_wadr_hold", {32'h0, WADR}, 40'h08);

    // Read 0x00 answered after 3 cycles
    do_read(8'h00, 1'b1);
    chk("rd_rden_n1", {39'h0, RDEN}, 40'h1);
    chk("rd_radr_n1", {32'h0, RADR}, 40'h00);
    wait_tx(k);
    chk("rd_latency", 40'(k), 40'd4);
    chk("rd_first_byte", {32'h0, TX_DATA}, 40'h4B);
    wait_idle(100);

    // Read 0x40 never answered: 'T' 17 cycles after RD_WAIT entry
    do_read(8'h40, 1'b0);
    chk("to_rden_n1", {39'h0, RDEN}, 40'h1);
    wait_tx(k);
    chk("to_latency", 40'(k), 40'd18);
    chk("to_byte", {32'h0, TX_DATA}, 40'h54);
    chk("to_radr_hold", {32'h0, RADR}, 40'h40);
    wait_idle(50);
    stray_req++;
    repeat (10) @(posedge CLK);
    #1;
    chk("stray_busy", {39'h0, BUSY}, 40'h0);
    chk("stray_txvld", {39'h0, TX_VLD}, 40'h0);

    // Backpressure on write and read responses
    tx_mode = 1;
    do_write(8'h10, 32'hCAFE_BABE);
    wait_idle(200);
    do_read(8'h10, 1'b1);
    wait_idle(300);
    tx_mode = 0;
    @(posedge CLK);
    #1;

    // Unknown command
    exp_tx.push_back(8'h45);
    send_byte(8'h41);
    chk("err_txvld", {39'h0, TX_VLD}, 40'h1);
    chk("err_byte", {32'h0, TX_DATA}, 40'h45);
    wait_idle(50);

    // Partial write abandoned by inter-byte timeout
    send_byte(8'h57);
    send_byte(8'h04);
    send_byte(8'hAA);
    chk("gap_busy_before", {39'h0, BUSY}, 40'h1);
    repeat (BYTE_TO + 20) @(posedge CLK);
    #1;
    chk("gap_busy_after", {39'h0, BUSY}, 40'h0);
    do_read(8'h04, 1'b1);
    wait_idle(100);

    // Reset in DATA
    send_byte(8'h57);
    send_byte(8'h20);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("rstd_busy_before", {39'h0, BUSY}, 40'h1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_reset("rst_data");
    RST = 1'b0;

    // Reset in RESP with the transmitter stalled
    tx_mode = 2;
    @(posedge CLK);
    #1;
    do_read(8'h00, 1'b1);
    wait_tx(k);
    chk("rstr_txvld_before", {39'h0, TX_VLD}, 40'h1);
    RST = 1'b1;
    exp_tx.delete();
    @(posedge CLK);
    #1;
    check_reset("rst_resp");
    RST = 1'b0;
    tx_mode = 0;
    @(posedge CLK);
    #1;

    // Recovery
    do_write(8'h20, 32'h0102_0304);
    wait_idle(50);
    do_read(8'h20, 1'b1);
    wait_idle(100);

    repeat (5) @(posedge CLK);
    #1;
    chk("left_tx", 40'(exp_tx.size()), 40'd0);
    chk("left_wr", 40'(exp_wr.size()), 40'd0);
    chk("left_rd", 40'(exp_rd.size()), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
